tdp_512x10_arbiter: RTL

TDP_512X10_ARBITER -- requirements
Module: tdp_512x10_arbiter

---
 rtl/tdp_arb_pkg.sv | 23 ++
 rtl/tdp_512x10_arbiter_if.sv | 28 ++
 rtl/tdp_rr_pick2.sv | 34 +++
 rtl/tdp_512x10_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/tdp_arb_pkg.sv
// Shared defaults, port-select encoding and flatten/slice helpers for the
// two-port RAM arbiter.
package tdp_arb_pkg;

    localparam int unsigned DW_DEF    = 512;
    localparam int unsigned AW_DEF    = 4;
    localparam int unsigned DEPTH_DEF = 10;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // LSB position of element idx in a flattened vector of w-bit elements
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/tdp_512x10_arbiter_if.sv
// Requester-side bus of the two-port RAM arbiter.
// err_valid exists only when TDP_ARB_RANGE_CHK_EN is defined.
interface tdp_512x10_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 512,
    parameter int unsigned AW   = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ*DW-1:0] rsp_rdata;
`ifdef TDP_ARB_RANGE_CHK_EN
    logic [NREQ-1:0]    err_valid;

    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, err_valid);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, err_valid);
`else
    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata);
`endif
endinterface

// File: rtl/tdp_rr_pick2.sv
// Round-robin first/second pick: scans valid from the pointer upward with wrap.
module tdp_rr_pick2 #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_first_c,
    output logic [NREQ-1:0] o_second_c,
    output logic            o_found1_c,
    output logic            o_found2_c
);
    logic [PW-1:0] w_idx;

    always_comb begin
        o_first_c  = '0;
        o_second_c = '0;
        o_found1_c = 1'b0;
        o_found2_c = 1'b0;
        w_idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = PW'((32'(i_ptr) + k) % NREQ);
            if (i_valid[w_idx]) begin
                if (!o_found1_c) begin
                    o_first_c[w_idx] = 1'b1;
                    o_found1_c       = 1'b1;
                end else if (!o_found2_c) begin
                    o_second_c[w_idx] = 1'b1;
                    o_found2_c        = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/tdp_512x10_arbiter.sv
// Round-robin arbiter granting up to two requesters per cycle onto a true
// dual-port RAM. Optional range check: TDP_ARB_RANGE_CHK_EN.
module tdp_512x10_arbiter
    import tdp_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned DW    = DW_DEF,
    parameter  int unsigned AW    = AW_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdp_512x10_arbiter_if.slave  bus,
    output logic                 weA,
    output logic [AW-1:0]        addrA,
    output logic [DW-1:0]        dinA,
    output logic                 weB,
    output logic [AW-1:0]        addrB,
    output logic [DW-1:0]        dinB,
    input  logic [DW-1:0]        doutA,
    input  logic [DW-1:0]        doutB
);
    if (DEPTH == 0 || DEPTH > (1 << AW)) begin : g_bad_depth
        $error("DEPTH does not fit the address width");
    end

    logic [PW-1:0]   r_rr_ptr;
    logic [NREQ-1:0] r_rsp_valid;
    port_sel_e       r_port_tag [NREQ];

    logic [NREQ-1:0] w_first, w_second, w_ready, w_oor;
    logic            w_found1, w_found2, w_coll, w_gnt_a, w_gnt_b;
    logic            w_we_a, w_we_b, w_oor_a, w_oor_b;
    logic [PW-1:0]   w_idx_a, w_idx_b, w_last;
    logic [AW-1:0]   w_addr_a, w_addr_b;
    logic [DW-1:0]   w_wdata_a, w_wdata_b;

    tdp_rr_pick2 #(.NREQ(NREQ)) u_pick (
        .i_valid    (bus.req_valid),
        .i_ptr      (r_rr_ptr),
        .o_first_c  (w_first),
        .o_second_c (w_second),
        .o_found1_c (w_found1),
        .o_found2_c (w_found2)
    );

`ifdef TDP_ARB_RANGE_CHK_EN
    logic [NREQ-1:0] r_err_valid;
    for (genvar i = 0; i < NREQ; i++) begin : g_oor
        assign w_oor[i] = 32'(bus.req_addr[i*AW +: AW]) >= DEPTH;
    end
`else
    assign w_oor = '0;
`endif

    // Grant resolution, collision filter and RAM port drive
    always_comb begin
        w_idx_a = '0;
        w_idx_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_first[k])  w_idx_a = PW'(k);
            if (w_second[k]) w_idx_b = PW'(k);
        end
        w_addr_a  = bus.req_addr[slice_lsb(32'(w_idx_a), AW) +: AW];
        w_addr_b  = bus.req_addr[slice_lsb(32'(w_idx_b), AW) +: AW];
        w_wdata_a = bus.req_wdata[slice_lsb(32'(w_idx_a), DW) +: DW];
        w_wdata_b = bus.req_wdata[slice_lsb(32'(w_idx_b), DW) +: DW];
        w_we_a    = bus.req_we[w_idx_a];
        w_we_b    = bus.req_we[w_idx_b];
        w_oor_a   = w_oor[w_idx_a];
        w_oor_b   = w_oor[w_idx_b];

        w_coll  = w_found2 && (w_addr_a == w_addr_b) && (w_we_a || w_we_b)
                  && !w_oor_a && !w_oor_b;
        w_gnt_a = rst_n && w_found1;
        w_gnt_b = rst_n && w_found2 && !w_coll;

        w_ready = '0;
        if (w_gnt_a) w_ready = w_ready | w_first;
        if (w_gnt_b) w_ready = w_ready | w_second;

        weA = 1'b0; addrA = '0; dinA = '0;
        weB = 1'b0; addrB = '0; dinB = '0;
        if (w_gnt_a && !w_oor_a) begin
            weA = w_we_a; addrA = w_addr_a; dinA = w_wdata_a;
        end
        if (w_gnt_b && !w_oor_b) begin
            weB = w_we_b; addrB = w_addr_b; dinB = w_wdata_b;
        end

        w_last = w_gnt_b ? w_idx_b : w_idx_a;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            for (int i = 0; i < NREQ; i++) r_port_tag[i] <= PORT_A;
`ifdef TDP_ARB_RANGE_CHK_EN
            r_err_valid <= '0;
`endif
        end else begin
            if (w_gnt_a) r_rr_ptr <= PW'(rr_next(32'(w_last), NREQ));
            r_rsp_valid <= w_ready & ~bus.req_we & ~w_oor;
            for (int i = 0; i < NREQ; i++) begin
                r_port_tag[i] <= (w_gnt_b && w_second[i]) ? PORT_B : PORT_A;
            end
`ifdef TDP_ARB_RANGE_CHK_EN
            r_err_valid <= w_ready & w_oor;
`endif
        end
    end

    assign bus.req_ready = w_ready;
    // Gating by rst_n drops a response whose grant immediately preceded reset
    assign bus.rsp_valid = r_rsp_valid & {NREQ{rst_n}};
`ifdef TDP_ARB_RANGE_CHK_EN
    assign bus.err_valid = r_err_valid & {NREQ{rst_n}};
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_rdata
        assign bus.rsp_rdata[i*DW +: DW] = (r_port_tag[i] == PORT_B) ? doutB : doutA;
    end
endmodule
